// File: rtl/writeback_sequencer.sv
// Register-file writeback sequencer: ALU results take priority, load responses queue in a FIFO.
// Optional build macro BETA_R31_SQUASH_EN suppresses register-file writes to register 31.
module writeback_sequencer #(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rc,
  input  logic [31:0] alu_wd,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [4:0]  ld_rc,
  input  logic [31:0] ld_wd,
  output logic [4:0]  Rc,
  output logic [31:0] WD,
  output logic        WERF,
  output logic [4:0]  pending
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = 5;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

`ifdef BETA_R31_SQUASH_EN
  localparam bit SQUASH_R31 = 1'b1;
`else
  localparam bit SQUASH_R31 = 1'b0;
`endif

  typedef struct packed {
    logic [4:0]  rc;
    logic [31:0] wd;
  } wb_entry_t;

  wb_entry_t        mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ld_ready_q, ld_ready_d;
  logic [4:0]       rc_q, rc_d;
  logic [31:0]      wd_q, wd_d;
  logic             werf_q, werf_d;
  logic             push_c, pop_c, issue_vld_c;
  wb_entry_t        issue_c;

  // Issue selection, FIFO bookkeeping and next-state for all registered outputs
  always_comb begin
    push_c      = ld_valid && ld_ready_q;
    pop_c       = !alu_valid && (cnt_q != '0);
    issue_vld_c = alu_valid || pop_c;
    issue_c     = alu_valid ? wb_entry_t'({alu_rc, alu_wd}) : mem_q[rd_ptr_q];

    rd_ptr_d = pop_c  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    wr_ptr_d = push_c ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    cnt_d    = cnt_q;
    if (push_c && !pop_c) cnt_d = cnt_q + CNT_W'(1);
    if (pop_c && !push_c) cnt_d = cnt_q - CNT_W'(1);
    ld_ready_d = (cnt_d < FULL_CNT);

    // A squashed write still consumes its slot but leaves Rc/WD untouched
    werf_d = issue_vld_c && !(SQUASH_R31 && (issue_c.rc == 5'd31));
    rc_d   = werf_d ? issue_c.rc : rc_q;
    wd_d   = werf_d ? issue_c.wd : wd_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      cnt_q      <= '0;
      ld_ready_q <= 1'b0;
      rc_q       <= '0;
      wd_q       <= '0;
      werf_q     <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      cnt_q      <= cnt_d;
      ld_ready_q <= ld_ready_d;
      rc_q       <= rc_d;
      wd_q       <= wd_d;
      werf_q     <= werf_d;
    end
  end

  // Payload storage needs no reset: entries are only read while counted as valid
  always_ff @(posedge clk) begin
    if (push_c) mem_q[wr_ptr_q] <= wb_entry_t'({ld_rc, ld_wd});
  end

  assign ld_ready = ld_ready_q;
  assign Rc       = rc_q;
  assign WD       = wd_q;
  assign WERF     = werf_q;
  assign pending  = cnt_q;

endmodule

// File: tb/tb_writeback_sequencer.sv
// Self-checking bench for writeback_sequencer against a queue-based reference model.
module tb_writeback_sequencer;

  localparam int DEPTH = 4;
`ifdef BETA_R31_SQUASH_EN
  localparam bit SQ = 1'b1;
`else
  localparam bit SQ = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        alu_valid = 1'b0;
  logic [4:0]  alu_rc = '0;
  logic [31:0] alu_wd = '0;
  logic        ld_valid = 1'b0;
  logic        ld_ready;
  logic [4:0]  ld_rc = '0;
  logic [31:0] ld_wd = '0;
  logic [4:0]  Rc;
  logic [31:0] WD;
  logic        WERF;
  logic [4:0]  pending;

  int checks = 0;
  int errors = 0;

  // Reference model state: expected outputs and a queue of accepted loads
  logic [36:0] mq[$];
  logic        e_werf = 1'b0;
  logic [4:0]  e_rc = '0;
  logic [31:0] e_wd = '0;
  logic        m_ready = 1'b0;
  logic [43:0] exp_v, obs_v;

  writeback_sequencer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_rc(alu_rc), .alu_wd(alu_wd),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rc(ld_rc), .ld_wd(ld_wd),
    .Rc(Rc), .WD(WD), .WERF(WERF), .pending(pending)
  );

  always #5 clk = ~clk;

  task automatic model_write(input logic [4:0] rc, input logic [31:0] wd);
    e_werf = !(SQ && rc == 5'd31);
    if (e_werf) begin
      e_rc = rc;
      e_wd = wd;
    end
  endtask

  // Advance the model by one edge using the inputs currently driven, then clock the DUT
  task automatic tick();
    logic acc;
    logic [36:0] head;
    acc = ld_valid && m_ready;
    if (alu_valid) model_write(alu_rc, alu_wd);
    else if (mq.size() > 0) begin
      head = mq.pop_front();
      model_write(head[36:32], head[31:0]);
    end else e_werf = 1'b0;
    if (acc) mq.push_back({ld_rc, ld_wd});
    m_ready = (mq.size() < DEPTH);
    exp_v = {e_werf, e_rc, e_wd, 5'(mq.size()), m_ready};
    @(posedge clk);
    #1;
    obs_v = {WERF, Rc, WD, pending, ld_ready};
  endtask

  task automatic model_reset();
    mq.delete();
    e_werf = 1'b0; e_rc = '0; e_wd = '0; m_ready = 1'b0;
  endtask

  task automatic idle_inputs();
    alu_valid = 1'b0; ld_valid = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({WERF, Rc, WD, pending, ld_ready} !== 44'd0) begin
      errors++; $display("FAIL reset_state: got %h expected 0", {WERF, Rc, WD, pending, ld_ready});
    end
    reset = 1'b0;
    model_reset();
    tick();
    checks++;
    if (obs_v !== exp_v || ld_ready !== 1'b1) begin
      errors++; $display("FAIL reset_release: got %h expected %h", obs_v, exp_v);
    end
  endtask

  task automatic test_alu_basic();
    alu_valid = 1'b1; alu_rc = 5'd5; alu_wd = 32'hDEADBEEF;
    tick();
    checks++;
    if (obs_v !== exp_v || {WERF, Rc, WD} !== {1'b1, 5'd5, 32'hDEADBEEF}) begin
      errors++; $display("FAIL alu_basic: got %h expected %h", obs_v, exp_v);
    end
    idle_inputs();
    tick();
    checks++;
    if (obs_v !== exp_v || WERF !== 1'b0 || Rc !== 5'd5) begin
      errors++; $display("FAIL alu_idle_hold: got %h expected %h", obs_v, exp_v);
    end
  endtask

  task automatic test_fill_and_drain();
    int acc_n = 0;
    ld_valid = 1'b1; alu_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      alu_rc = 5'($urandom_range(0, 30)); alu_wd = $urandom;
      ld_rc = 5'(acc_n + 1); ld_wd = 32'h1000 + 32'(acc_n + 1);
      if (ld_ready) acc_n++;
      tick();
      checks++;
      if (obs_v !== exp_v) begin
        errors++; $display("FAIL fill cyc %0d: got %h expected %h", i, obs_v, exp_v);
      end
    end
    checks++;
    if (pending !== 5'd4 || ld_ready !== 1'b0) begin
      errors++; $display("FAIL fill_full: got pending=%0d ready=%0b expected 4/0", pending, ld_ready);
    end
    ld_valid = 1'b0; alu_rc = 5'd7; alu_wd = 32'h0A1A0A1A;
    tick();
    checks++;
    if (obs_v !== exp_v || pending !== 5'd4) begin
      errors++; $display("FAIL alu_over_load: got %h expected %h", obs_v, exp_v);
    end
    idle_inputs();
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (obs_v !== exp_v || (i < 4 && (Rc !== 5'(i + 1) || WERF !== 1'b1))) begin
        errors++; $display("FAIL drain cyc %0d: got %h expected %h", i, obs_v, exp_v);
      end
    end
  endtask

  task automatic test_push_pop();
    ld_valid = 1'b1; alu_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (i >= 2) alu_valid = 1'b0;
      alu_rc = 5'($urandom_range(0, 30)); alu_wd = $urandom;
      ld_rc = 5'($urandom_range(0, 30)); ld_wd = $urandom;
      tick();
      checks++;
      if (obs_v !== exp_v || (i >= 1 && pending !== 5'd2)) begin
        errors++; $display("FAIL push_pop cyc %0d: got %h expected %h", i, obs_v, exp_v);
      end
    end
    idle_inputs();
    repeat (3) begin
      tick();
      checks++;
      if (obs_v !== exp_v) begin
        errors++; $display("FAIL push_pop_drain: got %h expected %h", obs_v, exp_v);
      end
    end
  endtask

  task automatic test_reset_mid();
    ld_valid = 1'b1; alu_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ld_rc = 5'(10 + i); ld_wd = $urandom; alu_rc = 5'd3; alu_wd = $urandom;
      tick();
    end
    idle_inputs();
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({WERF, Rc, WD, pending, ld_ready} !== 44'd0) begin
      errors++; $display("FAIL reset_mid: got %h expected 0", {WERF, Rc, WD, pending, ld_ready});
    end
    model_reset();
    @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (obs_v !== exp_v || WERF !== 1'b0) begin
        errors++; $display("FAIL post_reset cyc %0d: got %h expected %h", i, obs_v, exp_v);
      end
    end
  endtask

  task automatic test_r31();
    alu_valid = 1'b1; alu_rc = 5'd31; alu_wd = 32'h31313131;
    tick();
    checks++;
    if (obs_v !== exp_v || WERF !== !SQ) begin
      errors++; $display("FAIL r31: got %h expected %h", obs_v, exp_v);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      alu_valid = ($urandom_range(0, 99) < 45);
      ld_valid  = ($urandom_range(0, 99) < 55);
      alu_rc = 5'($urandom); alu_wd = $urandom;
      ld_rc  = 5'($urandom); ld_wd  = $urandom;
      tick();
      checks++;
      if (obs_v !== exp_v) begin
        errors++; $display("FAIL random cyc %0d: got %h expected %h", i, obs_v, exp_v);
      end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_alu_basic();
    test_fill_and_drain();
    test_push_pop();
    test_reset_mid();
    test_r31();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
